// File: rtl/d_ff_pkg.sv
// d_ff_pkg: build-variant selector and default gate delay for the d_flip_flop_reset family
package d_ff_pkg;
  typedef enum logic {IMPL_ALWAYS, IMPL_MASTER_SLAVE} impl_e;
  localparam int unsigned GATE_DELAY_DEFAULT = 0;
endpackage

// File: rtl/d_latch_reset.sv
// d_latch_reset: level-sensitive D latch, transparent while en=1, cleared asynchronously by rst
module d_latch_reset (
  input  logic D,
  input  logic en,
  input  logic rst,
  output logic Q,
  output logic Q_bar
);
  always_latch
    if (rst) Q <= 1'b0;
    else if (en) Q <= D;
  assign Q_bar = ~Q;
endmodule

// File: rtl/d_flip_flop_reset.sv
// d_flip_flop_reset: rising-edge D flip-flop with async active-high clear, behavioural or master-slave build
module d_flip_flop_reset
  import d_ff_pkg::*;
#(
  parameter impl_e       IMPL       = IMPL_ALWAYS,
  parameter int unsigned GATE_DELAY = GATE_DELAY_DEFAULT
) (
  input  logic D,
  input  logic clk,
  input  logic rst,
  output logic Q,
  output logic Q_bar
);
  // Propagation delays only matter in simulation; the synthesized netlist is zero-delay.
  logic unused_gate_delay;
  assign unused_gate_delay = ^GATE_DELAY;
  generate
    if (IMPL == IMPL_MASTER_SLAVE) begin : g_ms
      logic m, unused_m_bar;
      d_latch_reset u_master (.D(D), .en(~clk), .rst(rst), .Q(m), .Q_bar(unused_m_bar));
      d_latch_reset u_slave  (.D(m), .en(clk),  .rst(rst), .Q(Q), .Q_bar(Q_bar));
    end else begin : g_beh
      logic m, q;
      // Master stage kept explicitly so an edge coinciding with reset release loads 0, not D.
      always_latch
        if (rst) m <= 1'b0;
        else if (!clk) m <= D;
      always_ff @(posedge clk or posedge rst)
        if (rst) q <= 1'b0;
        else q <= m;
      assign Q = q;
      assign Q_bar = ~q;
    end
  endgenerate
endmodule

// File: tb/tb_d_flip_flop_reset.sv
// tb_d_flip_flop_reset: scoreboard bench comparing both build variants against an edge-rule reference model
module tb_d_flip_flop_reset;
  import d_ff_pkg::*;
  logic clk, rst, D;
  logic q_beh, qb_beh, q_ms, qb_ms;
  int n_chk = 0;
  int n_fail = 0;
  logic exp_q[$];
  event sample_ev;
  logic c_prev = 1'b0, r_prev = 1'b0, d_prev = 1'b0, q_exp = 1'bx;

  d_flip_flop_reset #(.IMPL(IMPL_ALWAYS)) u_beh (
    .D(D), .clk(clk), .rst(rst), .Q(q_beh), .Q_bar(qb_beh)
  );
  d_flip_flop_reset #(.IMPL(IMPL_MASTER_SLAVE)) u_ms (
    .D(D), .clk(clk), .rst(rst), .Q(q_ms), .Q_bar(qb_ms)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Reference: reset clears; a rising edge loads the pre-edge D only if reset was already low before the edge.
  task automatic apply(input logic c, input logic r, input logic d);
    logic rise;
    rise = !c_prev && c;
    clk = c;
    rst = r;
    D = d;
    if (r) q_exp = 1'b0;
    else if (rise && !r_prev) q_exp = d_prev;
    c_prev = c;
    r_prev = r;
    d_prev = d;
    #1;
    exp_q.push_back(q_exp);
    ->sample_ev;
  endtask

  initial forever begin
    logic e;
    @(sample_ev);
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_underflow at %0t: got empty queue expected entry", $time);
    end else begin
      e = exp_q.pop_front();
      if (!$isunknown(e)) begin
        chk("beh_q", q_beh, e);
        chk("ms_q", q_ms, e);
        chk("beh_qbar", qb_beh, ~e);
        chk("ms_qbar", qb_ms, ~e);
      end
    end
  end

  initial begin
    longint t0, tn, nc, nd, nr;
    logic c, r, d;
    apply(0, 0, 1);
    #4  apply(1, 0, 1);
    #50 apply(0, 0, 1);
    #20 apply(0, 1, 1);
    #20 apply(1, 1, 1);
    #20 apply(0, 1, 1);
    #20 apply(1, 0, 1);
    #99 apply(1, 0, 0);
    #9  apply(0, 0, 0);
    #199 apply(0, 0, 1);
    #99 apply(1, 0, 1);
    #89 apply(1, 0, 0);
    #9  apply(0, 0, 0);
    #99 apply(1, 0, 0);
    #99 apply(0, 0, 0);
    t0 = $time;
    nc = t0 + 100;
    nd = t0 + 201;
    nr = t0 + 430;
    c = c_prev;
    r = r_prev;
    d = d_prev;
    while (1) begin
      tn = nc < nd ? nc : nd;
      tn = nr < tn ? nr : tn;
      if (tn >= t0 + 10000) break;
      #(tn - $time);
      if (tn == nc) begin c = ~c; nc += 100; end
      if (tn == nd) begin d = 1'($urandom); nd += 201; end
      if (tn == nr) begin r = ($urandom_range(2) == 0); nr += 430; end
      apply(c, r, d);
    end
    #5;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
